// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared bank-count, FSM encoding and one-hot bank decode
// for the memory bank read path. No ports; imported by the other files.
package mem_bank_pkg;
    localparam int NUM_BANKS      = 4;
    localparam int BANK_SEL_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_SEL_WIDTH-1:0] sel);
        logic [NUM_BANKS-1:0] en;
        en      = '0;
        en[sel] = 1'b1;
        return en;
    endfunction
endpackage

// File: rtl/bank_read_mux_if.sv
// bank_read_mux_if: signal bundle of the bank read-return path.
//   requester side : i_rd_req, i_address, o_req_ready
//   bank side      : o_bank_rd_en, o_bank_addr, i_bank_data0..3
//   response side  : o_rd_data, o_rd_valid, i_rd_ready
// slave modport is the read mux itself; master is the surrounding logic.
interface bank_read_mux_if
    import mem_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) ();
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_address;
    logic                  o_req_ready;
    logic [NUM_BANKS-1:0]  o_bank_rd_en;
    logic [ADDR_WIDTH-3:0] o_bank_addr;
    logic [DATA_WIDTH-1:0] i_bank_data0;
    logic [DATA_WIDTH-1:0] i_bank_data1;
    logic [DATA_WIDTH-1:0] i_bank_data2;
    logic [DATA_WIDTH-1:0] i_bank_data3;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  i_rd_ready;

    modport slave (
        input  i_rd_req, i_address, i_bank_data0, i_bank_data1, i_bank_data2, i_bank_data3, i_rd_ready,
        output o_req_ready, o_bank_rd_en, o_bank_addr, o_rd_data, o_rd_valid
    );

    modport master (
        output i_rd_req, i_address, i_bank_data0, i_bank_data1, i_bank_data2, i_bank_data3, i_rd_ready,
        input  o_req_ready, o_bank_rd_en, o_bank_addr, o_rd_data, o_rd_valid
    );
endinterface

// File: rtl/bank_read_mux_data_select.sv
// bank_data_select: combinational 4:1 mux of the bank read-data buses.
//   sel             : bank number
//   d0..d3          : bank read data
//   data            : selected bank's data
module bank_data_select
    import mem_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [BANK_SEL_WIDTH-1:0] sel,
    input  logic [DATA_WIDTH-1:0]     d0,
    input  logic [DATA_WIDTH-1:0]     d1,
    input  logic [DATA_WIDTH-1:0]     d2,
    input  logic [DATA_WIDTH-1:0]     d3,
    output logic [DATA_WIDTH-1:0]     data
);
    // sel 2'b11 falls to bank 3, matching the demultiplexer's default branch
    always_comb data = (sel == 2'd0) ? d0 : (sel == 2'd1) ? d1 : (sel == 2'd2) ? d2 : d3;
endmodule

// File: rtl/bank_read_mux.sv
// bank_read_mux: read-return path of the 4-bank memory. Decodes the top
// address bits to a bank, pulses a one-hot read enable for one cycle,
// waits BANK_LATENCY cycles, captures that bank's data and offers it
// under a valid/ready handshake.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : bank_read_mux_if slave (request, bank and response signals)
module bank_read_mux
    import mem_bank_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BANK_LATENCY = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bank_read_mux_if.slave bus
);
    state_t                    state;
    state_t                    next_state;
    logic [BANK_SEL_WIDTH-1:0] sel;
    logic [2:0]                cnt;
    logic [DATA_WIDTH-1:0]     sel_data;

    bank_data_select #(.DATA_WIDTH(DATA_WIDTH)) u_select (
        .sel  (sel),
        .d0   (bus.i_bank_data0),
        .d1   (bus.i_bank_data1),
        .d2   (bus.i_bank_data2),
        .d3   (bus.i_bank_data3),
        .data (sel_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.i_rd_req ? ISSUE : IDLE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = (cnt == 3'd0) ? RESP : WAIT;
            default: next_state = bus.i_rd_ready ? IDLE : RESP;
        endcase
    end

    always_comb bus.o_req_ready = (state == IDLE);

    // Datapath registers; reset wins, so an in-flight read is dropped
    // before the capture in WAIT can happen.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sel              <= '0;
            cnt              <= '0;
            bus.o_bank_rd_en <= '0;
            bus.o_bank_addr  <= '0;
            bus.o_rd_data    <= '0;
            bus.o_rd_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_rd_req) begin
                    sel              <= bus.i_address[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
                    bus.o_bank_addr  <= bus.i_address[ADDR_WIDTH-3:0];
                    bus.o_bank_rd_en <= bank_onehot(bus.i_address[ADDR_WIDTH-1 -: BANK_SEL_WIDTH]);
                end
                ISSUE: begin
                    bus.o_bank_rd_en <= '0;
                    cnt              <= 3'(BANK_LATENCY - 1);
                end
                WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
                else begin
                    bus.o_rd_data  <= sel_data;
                    bus.o_rd_valid <= 1'b1;
                end
                default: if (bus.i_rd_ready) bus.o_rd_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_read_mux.sv
// tb_bank_read_mux: directed checks of bank_read_mux at BANK_LATENCY 1 and 3.
module tb_bank_read_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bank_read_mux_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus  ();
    bank_read_mux_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus3 ();

    bank_read_mux #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BANK_LATENCY(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    bank_read_mux #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BANK_LATENCY(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_rd_req = 1'b0; bus.i_address = '0; bus.i_rd_ready = 1'b0;
        bus.i_bank_data0 = 8'hFF; bus.i_bank_data1 = 8'hFF; bus.i_bank_data2 = 8'hFF; bus.i_bank_data3 = 8'hFF;
        bus3.i_rd_req = 1'b0; bus3.i_address = '0; bus3.i_rd_ready = 1'b1;
        bus3.i_bank_data0 = 8'hFF; bus3.i_bank_data1 = 8'hEE; bus3.i_bank_data2 = 8'hFF; bus3.i_bank_data3 = 8'hFF;
        repeat (2) step();
        check("rst_ready", bus.o_req_ready, 1);
        check("rst_rd_en", bus.o_bank_rd_en, 4'b0000);
        check("rst_addr", bus.o_bank_addr, 0);
        check("rst_data", bus.o_rd_data, 0);
        check("rst_valid", bus.o_rd_valid, 0);
        rst_n = 1'b1;
        step();
        check("idle_ready", bus.o_req_ready, 1);

        // single read, bank 2
        bus.i_address = 4'b1001; bus.i_bank_data2 = 8'hA5; bus.i_rd_ready = 1'b1; bus.i_rd_req = 1'b1;
        step();
        bus.i_rd_req = 1'b0;
        check("b2_rd_en", bus.o_bank_rd_en, 4'b0100);
        check("b2_addr", bus.o_bank_addr, 2'b01);
        check("b2_ready_busy", bus.o_req_ready, 0);
        step();
        check("b2_rd_en_off", bus.o_bank_rd_en, 4'b0000);
        check("b2_valid_early", bus.o_rd_valid, 0);
        step();
        check("b2_valid", bus.o_rd_valid, 1);
        check("b2_data", bus.o_rd_data, 8'hA5);
        step();
        check("b2_valid_drop", bus.o_rd_valid, 0);
        check("b2_ready_back", bus.o_req_ready, 1);

        // backpressure, bank 0
        bus.i_address = 4'b0011; bus.i_bank_data0 = 8'h3C; bus.i_rd_ready = 1'b0; bus.i_rd_req = 1'b1;
        step();
        check("bp_rd_en", bus.o_bank_rd_en, 4'b0001);
        check("bp_addr", bus.o_bank_addr, 2'b11);
        step();
        step();
        bus.i_bank_data0 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", bus.o_rd_valid, 1);
            check("bp_data_hold", bus.o_rd_data, 8'h3C);
            check("bp_ready_low", bus.o_req_ready, 0);
            if (i < 4) step();
        end
        bus.i_rd_ready = 1'b1; bus.i_rd_req = 1'b0;
        step();
        check("bp_valid_drop", bus.o_rd_valid, 0);
        check("bp_ready_back", bus.o_req_ready, 1);
        check("bp_data_kept", bus.o_rd_data, 8'h3C);

        // back-to-back with request held high
        bus.i_address = 4'b1100; bus.i_bank_data3 = 8'h11; bus.i_bank_data1 = 8'h22; bus.i_rd_req = 1'b1;
        step();
        check("bb1_rd_en", bus.o_bank_rd_en, 4'b1000);
        check("bb1_addr", bus.o_bank_addr, 2'b00);
        bus.i_address = 4'b0110;
        step();
        check("bb1_rd_en_off", bus.o_bank_rd_en, 4'b0000);
        check("bb1_addr_held", bus.o_bank_addr, 2'b00);
        step();
        check("bb1_valid", bus.o_rd_valid, 1);
        check("bb1_data", bus.o_rd_data, 8'h11);
        step();
        check("bb_gap_rd_en", bus.o_bank_rd_en, 4'b0000);
        check("bb_gap_valid", bus.o_rd_valid, 0);
        step();
        bus.i_rd_req = 1'b0;
        check("bb2_rd_en", bus.o_bank_rd_en, 4'b0010);
        check("bb2_addr", bus.o_bank_addr, 2'b10);
        step();
        step();
        check("bb2_valid", bus.o_rd_valid, 1);
        check("bb2_data", bus.o_rd_data, 8'h22);
        step();
        check("bb2_done", bus.o_rd_valid, 0);

        // reset while waiting on the bank
        bus.i_address = 4'b1001; bus.i_rd_req = 1'b1;
        step();
        bus.i_rd_req = 1'b0;
        check("mr_rd_en", bus.o_bank_rd_en, 4'b0100);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_ready", bus.o_req_ready, 1);
        check("mr_rd_en_off", bus.o_bank_rd_en, 4'b0000);
        check("mr_valid", bus.o_rd_valid, 0);
        check("mr_data", bus.o_rd_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_no_late_valid", bus.o_rd_valid, 0);
        end

        // BANK_LATENCY=3: bank 1 data becomes correct only just before capture
        bus3.i_address = 4'b0110; bus3.i_rd_req = 1'b1;
        step();
        bus3.i_rd_req = 1'b0;
        check("l3_rd_en", bus3.o_bank_rd_en, 4'b0010);
        check("l3_addr", bus3.o_bank_addr, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("l3_valid_early", bus3.o_rd_valid, 0);
        end
        bus3.i_bank_data1 = 8'h5A;
        step();
        check("l3_valid", bus3.o_rd_valid, 1);
        check("l3_data", bus3.o_rd_data, 8'h5A);
        step();
        check("l3_done", bus3.o_rd_valid, 0);
        check("l3_ready", bus3.o_req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
